// File: rtl/rca_accumulator.sv
// rtl/rca_accumulator.sv - frame accumulator built on a ripple-carry adder

// Plain ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module rca_ripple_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] carry;

  assign carry[0] = cin_i;

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_fa
      // Full-adder cell: sum bit plus carry into the next stage
      assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  endgenerate

  assign cout_o = carry[W];

endmodule

// Sums LEN accepted operand/carry samples, then holds one result until drained.
module rca_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = N + 4,
  parameter int LEN   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int              CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [ACC_W-1:0] opnd_d;
  logic [ACC_W-1:0] acc_d;
  logic             carry_d;
  logic             ovf_d;

  // Operand is unsigned, so it is zero-extended up to the accumulator width
  assign opnd_d = {{(ACC_W - N){1'b0}}, in_data};

  rca_ripple_add #(
    .W (ACC_W)
  ) u_add (
    .a_i    (acc_q),
    .b_i    (opnd_d),
    .cin_i  (in_cin),
    .sum_o  (acc_d),
    .cout_o (carry_d)
  );

  // Overflow is sticky across the frame: once a carry leaves the MSB it stays set
  assign ovf_d = ovf_q | carry_d;

  // Frame FSM; handshake outputs are registered so they depend on state only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      // Abort wins over any accept or result handshake in the same cycle
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            if (cnt_q == LAST) begin
              cnt_q       <= '0;
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          // Result stays frozen until taken; new samples wait for the next cycle
          if (out_ready) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_rca_accumulator.sv
// tb/tb_rca_accumulator.sv - directed and model-checked bench for rca_accumulator
module tb_rca_accumulator;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_cin;
  logic       out_ready;

  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_sum;
  logic       out_ovf;

  logic       in_ready6;
  logic       out_valid6;
  logic [5:0] out_sum6;
  logic       out_ovf6;

  logic       in_valid1;
  logic       out_ready1;
  logic       in_ready1;
  logic       out_valid1;
  logic [4:0] out_sum1;
  logic       out_ovf1;

  int checks = 0;
  int errors = 0;

  rca_accumulator #(.N(4), .ACC_W(8), .LEN(8)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  rca_accumulator #(.N(4), .ACC_W(6), .LEN(8)) dut6 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready6), .in_data(in_data), .in_cin(in_cin),
    .out_valid(out_valid6), .out_ready(out_ready), .out_sum(out_sum6), .out_ovf(out_ovf6)
  );

  rca_accumulator #(.N(4), .ACC_W(5), .LEN(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data), .in_cin(in_cin),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1), .out_ovf(out_ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the random phase (8-bit and 6-bit accumulators)
  logic       m_done;
  int         m_cnt;
  logic [7:0] m_acc8;
  logic [5:0] m_acc6;
  logic       m_ovf8;
  logic       m_ovf6;
  logic [8:0] s8;
  logic [6:0] s6;
  int         frames;
  int         cyc;

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 4'h0; in_cin = 1'b0;
    out_ready = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);
    #3;
    rst = 1'b0;
    chk("rel_in_ready", in_ready, 1);

    // 1/2: eight samples of F+1 -> 0x80 in 8 bits, 0x00 with overflow in 6 bits
    in_valid = 1'b1; in_data = 4'hF; in_cin = 1'b1;
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t1_valid", out_valid, (k == 8));
      chk("len1_valid", out_valid1, k[0]);
      chk("len1_ready", in_ready1, !k[0]);
      if (k[0]) chk("len1_sum", out_sum1, 5'h10);
    end
    chk("t1_sum", out_sum, 8'h80);
    chk("t1_ovf", out_ovf, 0);
    chk("t1_in_ready", in_ready, 0);
    chk("t2_sum6", out_sum6, 6'h00);
    chk("t2_ovf6", out_ovf6, 1);
    in_valid = 1'b0; in_valid1 = 1'b0;
    tick();
    chk("t1_drain_valid", out_valid, 0);
    chk("t1_drain_ready", in_ready, 1);
    chk("t1_drain_sum", out_sum, 0);

    // 3: result held under back-pressure while in_valid stays high
    in_valid = 1'b1; in_data = 4'h1; in_cin = 1'b0; out_ready = 1'b0;
    repeat (8) tick();
    chk("t3_valid", out_valid, 1);
    chk("t3_sum", out_sum, 8'h08);
    in_data = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_sum", out_sum, 8'h08);
      chk("t3_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_rel_ready", in_ready, 1);
    chk("t3_rel_valid", out_valid, 0);
    chk("t3_rel_sum", out_sum, 0);
    out_ready = 1'b0; in_data = 4'h2; in_cin = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t3_f2_valid", out_valid, (k == 8));
    end
    chk("t3_f2_sum", out_sum, 8'h18);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // 4: clear mid-frame drops partial sum and the simultaneous sample
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h5; in_cin = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    chk("t4_clr_sum", out_sum, 0);
    chk("t4_clr_valid", out_valid, 0);
    clear = 1'b0; in_data = 4'h1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t4_valid", out_valid, (k == 8));
    end
    chk("t4_sum", out_sum, 8'h08);
    chk("t4_ovf", out_ovf, 0);
    clear = 1'b1; in_valid = 1'b0;
    tick();
    chk("t4_clrdone_valid", out_valid, 0);
    chk("t4_clrdone_ready", in_ready, 1);
    chk("t4_clrdone_sum", out_sum, 0);
    clear = 1'b0;

    // 5: asynchronous reset between edges mid-frame
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'h3; in_cin = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_sum", out_sum, 0);
    #1 rst = 1'b0;
    in_cin = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t5_valid", out_valid, (k == 8));
    end
    chk("t5_sum", out_sum, 8'h20);
    chk("t5_ovf", out_ovf, 0);
    in_valid = 1'b0;
    tick();

    // 6: random traffic against a behavioural model
    m_done = 1'b0; m_cnt = 0; m_acc8 = '0; m_acc6 = '0; m_ovf8 = 1'b0; m_ovf6 = 1'b0;
    frames = 0; cyc = 0;
    while (frames < 200 && cyc < 20000) begin
      chk("r_in_ready", in_ready, !m_done);
      chk("r_out_valid", out_valid, m_done);
      chk("r_out_valid6", out_valid6, m_done);
      if (m_done) begin
        chk("r_sum8", out_sum, m_acc8);
        chk("r_ovf8", out_ovf, m_ovf8);
        chk("r_sum6", out_sum6, m_acc6);
        chk("r_ovf6", out_ovf6, m_ovf6);
      end
      in_valid  = 1'($urandom_range(1));
      in_data   = 4'($urandom_range(15));
      in_cin    = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      tick();
      if (!m_done) begin
        if (in_valid) begin
          s8 = m_acc8 + in_data + in_cin;
          s6 = m_acc6 + in_data + in_cin;
          m_acc8 = s8[7:0]; m_ovf8 = m_ovf8 | s8[8];
          m_acc6 = s6[5:0]; m_ovf6 = m_ovf6 | s6[6];
          m_cnt++;
          if (m_cnt == 8) begin
            m_cnt = 0;
            m_done = 1'b1;
          end
        end
      end else if (out_ready) begin
        m_acc8 = '0; m_acc6 = '0; m_ovf8 = 1'b0; m_ovf6 = 1'b0;
        m_done = 1'b0;
        frames++;
      end
      cyc++;
    end
    chk("r_frames", frames, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
